// File: rtl/case_4_mac_frame_acc_pkg.sv
// case_4_mac_frame_acc_pkg: widths, state encoding and saturation bounds for the frame MAC
package case_4_mac_frame_acc_pkg;
  localparam int A_W       = 9;
  localparam int B_W       = 7;
  localparam int FULL_W    = A_W + B_W;
  localparam int PROD_W    = 13;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int ACC_W     = PROD_W + CNT_W;
  localparam int OUT_W     = 14;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    EMIT  = 2'd2
  } state_t;
endpackage

// File: rtl/case_4_mac_frame_acc_if.sv
// case_4_mac_frame_acc_if: operand stream in, frame result stream out
interface case_4_mac_frame_acc_if;
  import case_4_mac_frame_acc_pkg::*;
  logic signed [A_W-1:0]   s_a;
  logic signed [B_W-1:0]   s_b;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [OUT_W-1:0] m_data;
  logic                    m_sat;
  logic                    m_valid;
  logic                    m_ready;
  modport slave (input s_a, s_b, s_valid, m_ready, output s_ready, m_data, m_sat, m_valid);
  modport master (output s_a, s_b, s_valid, m_ready, input s_ready, m_data, m_sat, m_valid);
endinterface

// File: rtl/case_4_mac_frame_acc_sat.sv
// case_4_mac_frame_acc_sat: clamps a full-width frame sum into the signed output range
module case_4_mac_frame_acc_sat
  import case_4_mac_frame_acc_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_sat
);
  logic w_hi, w_lo;
  assign w_hi  = i_val > SAT_MAX;
  assign w_lo  = i_val < SAT_MIN;
  assign o_sat = w_hi || w_lo;
  assign o_val = w_hi ? OUT_W'(SAT_MAX) : w_lo ? OUT_W'(SAT_MIN) : i_val[OUT_W-1:0];
endmodule

// File: rtl/case_4_mac_frame_acc.sv
// case_4_mac_frame_acc: signed MAC summing FRAME_LEN wrapped products into one saturated result
module case_4_mac_frame_acc
  import case_4_mac_frame_acc_pkg::*;
(
  input logic                  ap_clk,
  input logic                  ap_rst,
  case_4_mac_frame_acc_if.slave io
);
  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [PROD_W-1:0] r_p;
  logic                    r_p_vld;
  logic                    r_m_valid;
  logic                    r_m_sat;
  logic signed [OUT_W-1:0] r_m_data;
  logic signed [FULL_W-1:0] w_a, w_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_sat_data;
  logic                    w_sat_flag, w_xfer, w_last;
  assign w_a        = FULL_W'(io.s_a);
  assign w_b        = FULL_W'(io.s_b);
  // keep only the low product bits: the product deliberately wraps
  assign w_prod     = PROD_W'(w_a * w_b);
  assign w_sum      = r_acc + ACC_W'(r_p);
  assign w_xfer     = io.s_valid && io.s_ready;
  assign w_last     = r_cnt == CNT_W'(FRAME_LEN - 1);
  assign io.s_ready = (r_state == ACCUM) && !ap_rst;
  assign io.m_valid = r_m_valid;
  assign io.m_data  = r_m_data;
  assign io.m_sat   = r_m_sat;
  case_4_mac_frame_acc_sat u_sat (
    .i_val (w_sum),
    .o_val (w_sat_data),
    .o_sat (w_sat_flag)
  );
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state   <= ACCUM;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_p       <= '0;
      r_p_vld   <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_sat   <= 1'b0;
    end else begin
      r_p_vld <= w_xfer;
      if (w_xfer) r_p <= w_prod;
      // the final product of a frame is still in r_p during FLUSH and is folded in here
      if (r_state == FLUSH) begin
        r_acc     <= '0;
        r_m_data  <= w_sat_data;
        r_m_sat   <= w_sat_flag;
        r_m_valid <= 1'b1;
        r_state   <= EMIT;
      end else if (r_p_vld) r_acc <= w_sum;
      if (w_xfer) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_state <= FLUSH;
      end
      if (r_state == EMIT && io.m_ready) begin
        r_m_valid <= 1'b0;
        r_state   <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_case_4_mac_frame_acc.sv
// tb_case_4_mac_frame_acc: vector table, corner sequences and random traffic against a frame-sum model
module tb_case_4_mac_frame_acc;
  import case_4_mac_frame_acc_pkg::*;
  logic ap_clk = 1'b0;
  logic ap_rst;
  case_4_mac_frame_acc_if bus();
  case_4_mac_frame_acc dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .io(bus));
  always #5 ap_clk = ~ap_clk;

  typedef struct { int a; int b; int hold; int d; int s; } vec_t;
  vec_t tbl[6];
  int n_cmp = 0, n_fail = 0;
  int cnt = 0, sum = 0, exp_data = 0, exp_sat = 0, n_frames = 0, n_out = 0;
  bit busy = 0, lag = 0, last_xi = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int wrap(int v);
    int p = v & ((1 << PROD_W) - 1);
    return p >= (1 << (PROD_W - 1)) ? p - (1 << PROD_W) : p;
  endfunction

  function automatic int clamp(int v);
    int hi = (1 << (OUT_W - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction

  task automatic step();
    bit xi, xo;
    int sa, sb;
    @(negedge ap_clk);
    chk("s_ready", int'(bus.s_ready), int'(!busy && !ap_rst));
    chk("m_valid", int'(bus.m_valid), int'(busy && !lag));
    if (busy && !lag) begin
      chk("m_data", int'(bus.m_data), exp_data);
      chk("m_sat", int'(bus.m_sat), exp_sat);
    end
    xi = bus.s_valid && bus.s_ready;
    xo = bus.m_valid && bus.m_ready;
    sa = int'(bus.s_a);
    sb = int'(bus.s_b);
    @(posedge ap_clk);
    #1;
    last_xi = xi;
    if (ap_rst) begin
      n_frames -= int'(busy);
      cnt = 0; sum = 0; busy = 0; lag = 0;
    end else begin
      if (xo) begin n_out++; busy = 0; end
      lag = 0;
      if (xi) begin
        sum += wrap(sa * sb);
        cnt++;
        if (cnt == FRAME_LEN) begin
          exp_data = clamp(sum);
          exp_sat = int'(exp_data != sum);
          busy = 1; lag = 1; cnt = 0; sum = 0;
          n_frames++;
        end
      end
    end
  endtask

  task automatic feed(input int a, input int b, input int n);
    int k = 0, g = 0;
    bus.s_a = A_W'(a);
    bus.s_b = B_W'(b);
    bus.s_valid = 1'b1;
    while (k < n && g < 40) begin
      step();
      if (last_xi) k++;
      g++;
    end
    chk("feed_accepted", k, n);
    bus.s_valid = 1'b0;
  endtask

  task automatic run_frame(input int a, input int b, input int hold, output int d, output int s, output int lat);
    bus.m_ready = (hold == 0);
    feed(a, b, FRAME_LEN);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      step();
      lat++;
    end
    d = int'(bus.m_data);
    s = int'(bus.m_sat);
    repeat (hold) step();
    bus.m_ready = 1'b1;
    step();
    chk("s_ready_after_emit", int'(bus.s_ready), 1);
  endtask

  initial begin
    int d, s, lat;
    tbl[0] = '{a: 3,    b: 5,   hold: 0,  d: 60,    s: 0};
    tbl[1] = '{a: 100,  b: 50,  hold: 0,  d: -8192, s: 1};
    tbl[2] = '{a: -256, b: -64, hold: 0,  d: 0,     s: 0};
    tbl[3] = '{a: 64,   b: 63,  hold: 0,  d: 8191,  s: 1};
    tbl[4] = '{a: -64,  b: 64,  hold: 0,  d: -8192, s: 1};
    tbl[5] = '{a: 7,    b: -3,  hold: 10, d: -84,   s: 0};
    ap_rst = 1'b1;
    bus.s_a = '0; bus.s_b = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_m_sat", int'(bus.m_sat), 0);
    chk("rst_s_ready", int'(bus.s_ready), 0);
    step();
    ap_rst = 1'b0;
    step();
    foreach (tbl[i]) begin
      run_frame(tbl[i].a, tbl[i].b, tbl[i].hold, d, s, lat);
      chk($sformatf("vec%0d_data", i), d, tbl[i].d);
      chk($sformatf("vec%0d_sat", i), s, tbl[i].s);
      chk($sformatf("vec%0d_latency", i), lat, 1);
    end
    // reset mid-frame discards the partial sum
    bus.m_ready = 1'b1;
    feed(10, 10, 2);
    ap_rst = 1'b1;
    step();
    chk("midrst_m_data", int'(bus.m_data), 0);
    chk("midrst_m_sat", int'(bus.m_sat), 0);
    chk("midrst_m_valid", int'(bus.m_valid), 0);
    step();
    ap_rst = 1'b0;
    run_frame(1, 1, 0, d, s, lat);
    chk("after_rst_data", d, 4);
    // reset while a result is pending discards it
    bus.m_ready = 1'b0;
    feed(5, 5, FRAME_LEN);
    repeat (3) step();
    chk("pending_valid", int'(bus.m_valid), 1);
    ap_rst = 1'b1;
    step();
    chk("pending_dropped", int'(bus.m_valid), 0);
    ap_rst = 1'b0;
    run_frame(1, 1, 0, d, s, lat);
    chk("after_emit_rst_data", d, 4);
    repeat (600) begin
      bus.s_valid = $urandom_range(0, 3) != 0;
      bus.s_a = A_W'($urandom_range(0, 511));
      bus.s_b = B_W'($urandom_range(0, 127));
      bus.m_ready = $urandom_range(0, 2) != 0;
      step();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (8) step();
    chk("frames_out", n_out, n_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
